key_debounce: RTL

Input-conditioning stage between the experiment-board push buttons and the SOPC display/data I/O block. It synchronises the raw active-low key pins, debounces each key with a per-key state machine, and emits clean level, press, release and strobe signals. The downstream I/O block uses the strobes to step its two hex digit registers (tens/ones), so it no longer has to poll raw pins on a 1 Hz clock.

---
 rtl/key_debounce.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, debounce FSM and press/release/strobe pulse generator
//
// Purpose:
//   Conditions NKEYS raw active-low push-button pins for the display/data I/O
//   block. Each key is synchronised (2 flops), debounced by its own FSM, and
//   produces a clean level plus one-cycle press, release and strobe pulses.
//
// Optional feature:
//   KEY_REPEAT_EN - when defined, key_strobe_o also pulses REPEAT_DELAY cycles
//   after a press and every REPEAT_RATE cycles thereafter while the key is held.
//   When undefined, key_strobe_o equals key_press_o.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous reset, active-high
//   key_n_i        in   [NKEYS] raw key pins, active-low, asynchronous to clk
//   key_level_o    out  [NKEYS] debounced state, 1 = pressed
//   key_press_o    out  [NKEYS] one-cycle pulse on accepted press
//   key_release_o  out  [NKEYS] one-cycle pulse on accepted release
//   key_strobe_o   out  [NKEYS] one-cycle pulse on press (plus auto-repeats)

module key_debounce #(
   parameter int NKEYS        = 2,
   parameter int DEB_CYCLES   = 1_000_000,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NKEYS-1:0] key_n_i,
   output logic [NKEYS-1:0] key_level_o,
   output logic [NKEYS-1:0] key_press_o,
   output logic [NKEYS-1:0] key_release_o,
   output logic [NKEYS-1:0] key_strobe_o
);

   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] HELD         = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   if (DEB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
      $error("key_debounce: DEB_CYCLES must be >= 2 and repeat timings >= 1");
   end

   logic [NKEYS-1:0]         sync1_q, sync1_d;
   logic [NKEYS-1:0]         sync2_q, sync2_d;
   logic [NKEYS-1:0][1:0]    state_q, state_d;
   logic [NKEYS-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NKEYS-1:0]         level_q, level_d;
   logic [NKEYS-1:0]         press_q, press_d;
   logic [NKEYS-1:0]         release_q, release_d;

`ifdef KEY_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW      = $clog2(RPT_MAX + 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);
   localparam logic [RW-1:0] RPT_ONE = RW'(1);

   logic [NKEYS-1:0][RW-1:0] rcnt_q, rcnt_d;
   // 0: waiting for the initial delay, 1: running at the repeat rate
   logic [NKEYS-1:0]         rphase_q, rphase_d;
   logic [NKEYS-1:0]         strobe_q, strobe_d;
`endif

   always_comb begin
      // Synchroniser shifts raw pins in; inverted sense is handled at use sites.
      sync1_d   = key_n_i;
      sync2_d   = sync1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
`ifdef KEY_REPEAT_EN
      rcnt_d    = rcnt_q;
      rphase_d  = rphase_q;
      strobe_d  = '0;
`endif
      for (int k = 0; k < NKEYS; k++) begin
         case (state_q[k])
            IDLE: begin
               if (!sync2_q[k]) begin
                  state_d[k] = PRESS_WAIT;
                  cnt_d[k]   = CNT_ONE;
               end
            end
            PRESS_WAIT: begin
               if (sync2_q[k]) begin
                  state_d[k] = IDLE;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == DEB_LAST) begin
                  state_d[k] = HELD;
                  cnt_d[k]   = '0;
                  level_d[k] = 1'b1;
                  press_d[k] = 1'b1;
`ifdef KEY_REPEAT_EN
                  strobe_d[k] = 1'b1;
                  rcnt_d[k]   = '0;
                  rphase_d[k] = 1'b0;
`endif
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_ONE;
               end
            end
            HELD: begin
               if (sync2_q[k]) begin
                  state_d[k] = RELEASE_WAIT;
                  cnt_d[k]   = CNT_ONE;
`ifdef KEY_REPEAT_EN
               end else if (rcnt_q[k] == (rphase_q[k] ? RR_LAST : RD_LAST)) begin
                  strobe_d[k] = 1'b1;
                  rcnt_d[k]   = '0;
                  rphase_d[k] = 1'b1;
               end else begin
                  rcnt_d[k] = rcnt_q[k] + RPT_ONE;
`endif
               end
            end
            RELEASE_WAIT: begin
               // Repeat counter is left untouched here so a bounce back to
               // HELD resumes the repeat schedule where it stopped.
               if (!sync2_q[k]) begin
                  state_d[k] = HELD;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == DEB_LAST) begin
                  state_d[k]   = IDLE;
                  cnt_d[k]     = '0;
                  level_d[k]   = 1'b0;
                  release_d[k] = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_ONE;
               end
            end
            default: begin
               state_d[k] = IDLE;
               cnt_d[k]   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         state_q   <= {NKEYS{IDLE}};
         cnt_q     <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

`ifdef KEY_REPEAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt_q   <= '0;
         rphase_q <= '0;
         strobe_q <= '0;
      end else begin
         rcnt_q   <= rcnt_d;
         rphase_q <= rphase_d;
         strobe_q <= strobe_d;
      end
   end

   assign key_strobe_o = strobe_q;
`else
   assign key_strobe_o = press_q;
`endif

   assign key_level_o   = level_q;
   assign key_press_o   = press_q;
   assign key_release_o = release_q;

endmodule
